dircc_node_mem_arbiter: RTL

//  Shares one node's single-port on-chip RAM (32-bit, byte-enabled, 1-cycle read latency)

---
 rtl/dircc_mem_pkg.sv | 24 ++
 rtl/dircc_node_mem_arbiter_if.sv | 25 ++
 rtl/dircc_rr_arb2.sv | 36 +++
 rtl/dircc_node_mem_arbiter.sv | 97 +++++++++
 4 files changed

// File: rtl/dircc_mem_pkg.sv
// Shared widths, depth and record types for the node RAM arbiter.
// Request and read-return tag layouts are common to the top and the bench.
package dircc_mem_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;
    localparam int DEPTH  = 5120;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic              rd;
        logic              wr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic valid;
        logic master;
        logic oor;
    } rd_tag_t;

endpackage

// File: rtl/dircc_node_mem_arbiter_if.sv
// One Avalon-MM pipelined master link with a fixed one-cycle read response.
// The master modport is the requester side; the slave modport is the arbiter side.
interface dircc_node_mem_arbiter_if;
    import dircc_mem_pkg::*;

    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/dircc_rr_arb2.sv
// Two-way round-robin arbiter: single grant per cycle, preference flips to the
// other requester after every grant and holds while nothing is granted.
module dircc_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);

    logic ptr_q;  // 1 = m1 preferred
    logic ptr_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) ptr_q <= 1'b0;
        else       ptr_q <= ptr_d;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) ptr_d = grant_o[0];
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant_o = 2'b00;
        unique case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/dircc_node_mem_arbiter.sv
// Shares the node's single-port RAM between the Nios data master (m0) and the
// message/DMA engine (m1): one access per cycle, fixed one-cycle read return.
module dircc_node_mem_arbiter #(
    parameter int DEPTH = dircc_mem_pkg::DEPTH,
    parameter logic [dircc_mem_pkg::DATA_W-1:0] OOR_RDATA = '0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              mem_reset_req,
    dircc_node_mem_arbiter_if.slave           m0,
    dircc_node_mem_arbiter_if.slave           m1,
    output logic [dircc_mem_pkg::ADDR_W-1:0]  mem_address,
    output logic [dircc_mem_pkg::BE_W-1:0]    mem_byteenable,
    output logic                              mem_chipselect,
    output logic                              mem_write,
    output logic [dircc_mem_pkg::DATA_W-1:0]  mem_writedata,
    output logic                              mem_clken,
    input  logic [dircc_mem_pkg::DATA_W-1:0]  mem_readdata
);
    import dircc_mem_pkg::*;

    localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];

    mem_req_t          req0, req1, sel;
    logic [1:0]        req_ok, grant;
    logic              granted, sel_oor;
    rd_tag_t           tag_q, tag_d;
    logic [DATA_W-1:0] rdata_ret, hold0_q, hold1_q;
    logic              rdv0, rdv1;

    always_comb begin
        req0.addr  = m0.address;
        req0.be    = m0.byteenable;
        req0.rd    = m0.read;
        req0.wr    = m0.write;
        req0.wdata = m0.writedata;
        req1.addr  = m1.address;
        req1.be    = m1.byteenable;
        req1.rd    = m1.read;
        req1.wr    = m1.write;
        req1.wdata = m1.writedata;
    end

    // Reset and a RAM reset request both freeze arbitration entirely.
    assign req_ok = {m1.read | m1.write, m0.read | m0.write} & {2{~reset & ~mem_reset_req}};

    dircc_rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req_ok),
        .advance_i (|req_ok),
        .grant_o   (grant)
    );

    assign granted = |grant;
    assign sel     = grant[1] ? req1 : req0;
    assign sel_oor = {1'b0, sel.addr} >= DEPTH_W;

    assign mem_address    = sel.addr;
    assign mem_byteenable = sel.wr ? sel.be : '1;
    assign mem_chipselect = granted & ~sel_oor;
    assign mem_write      = granted & sel.wr;
    assign mem_writedata  = sel.wdata;
    assign mem_clken      = 1'b1;

    assign m0.waitrequest = ~grant[0];
    assign m1.waitrequest = ~grant[1];

    // Read-and-write together is a write, so only a pure read earns a response.
    always_comb begin
        tag_d.valid  = granted & sel.rd & ~sel.wr;
        tag_d.master = grant[1];
        tag_d.oor    = sel_oor;
    end

    always_ff @(posedge clk) begin
        if (reset) tag_q <= '0;
        else       tag_q <= tag_d;
    end

    // A tag still in flight when reset rises must not surface as a response.
    assign rdata_ret = tag_q.oor ? OOR_RDATA : mem_readdata;
    assign rdv0      = tag_q.valid & ~tag_q.master & ~reset;
    assign rdv1      = tag_q.valid &  tag_q.master & ~reset;

    // NOTE: the held read data is pure datapath, qualified by readdatavalid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (rdv0) hold0_q <= rdata_ret;
        if (rdv1) hold1_q <= rdata_ret;
    end

    assign m0.readdatavalid = rdv0;
    assign m1.readdatavalid = rdv1;
    assign m0.readdata      = rdv0 ? rdata_ret : hold0_q;
    assign m1.readdata      = rdv1 ? rdata_ret : hold1_q;

endmodule
